// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for single-byte commands: double-flop synchronised RX, mid-bit sampling,
// registered byte with ready/overrun/framing flags acknowledged by clr_rdy.
module uart_cmd_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          rx_meta_p0, rx_sync_p1, rx_prev_p2;
    logic [1:0]    warm;
    logic          armed;
    logic          fall, sample, byte_ok, frame_bad;

    // Synchroniser and edge flop; armed only once the line has been seen high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
            warm       <= 2'b00;
            armed      <= 1'b0;
        end else begin
            rx_meta_p0 <= RX;
            rx_sync_p1 <= rx_meta_p0;
            rx_prev_p2 <= rx_sync_p1;
            warm       <= {warm[0], 1'b1};
            if (warm == 2'b11 && rx_sync_p1)
                armed <= 1'b1;
        end
    end

    assign fall   = armed & rx_prev_p2 & ~rx_sync_p1;
    assign sample = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        if (state != IDLE)
            baud_nxt = sample ? FULL_LOAD : baud_cnt - 1'b1;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    baud_nxt  = HALF_LOAD;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_sync_p1) begin
                        state_nxt = IDLE;
                        baud_nxt  = '0;
                    end else begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_nxt = {rx_sync_p1, shift_reg[7:1]};
                    bit_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                    byte_ok   = rx_sync_p1;
                    frame_bad = ~rx_sync_p1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output flags: a same-cycle set takes priority over the clr_rdy acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            if (byte_ok && (!rdy || clr_rdy)) begin
                rx_data <= shift_reg;
                rdy     <= 1'b1;
            end else if (clr_rdy) begin
                rdy <= 1'b0;
            end
            if (byte_ok && rdy && !clr_rdy)
                ovr_err <= 1'b1;
            else if (clr_rdy)
                ovr_err <= 1'b0;
            if (frame_bad)
                frm_err <= 1'b1;
            else if (clr_rdy)
                frm_err <= 1'b0;
        end
    end

endmodule
